// File: rtl/hamming_rx_deframer_pkg.sv
// Shared constants and types for the SECDED Hamming(7,4)+parity receive deframer.
package hamming_rx_deframer_pkg;

  localparam int CW_BITS  = 8;
  localparam int NIB_BITS = 4;

  // Codeword bit positions; index 0 is the first bit on the wire.
  localparam int P1   = 0;
  localparam int P2   = 1;
  localparam int D0   = 2;
  localparam int P4   = 3;
  localparam int D1   = 4;
  localparam int D2   = 5;
  localparam int D3   = 6;
  localparam int PALL = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } state_e;

endpackage

// File: rtl/hamming_rx_deframer_dec.sv
// Combinational SECDED decoder: 8-bit codeword in, corrected nibble and error class out.
module hamming_secded_dec
  import hamming_rx_deframer_pkg::*;
(
  input  logic [CW_BITS-1:0]  cw,
  output logic [NIB_BITS-1:0] nib,
  output logic                sgl_err,
  output logic                dbl_err
);

  logic [2:0]         syn;
  logic               pe;
  logic [CW_BITS-1:0] fix;

  always_comb begin
    syn = {cw[P4] ^ cw[D1] ^ cw[D2] ^ cw[D3],
           cw[P2] ^ cw[D0] ^ cw[D2] ^ cw[D3],
           cw[P1] ^ cw[D0] ^ cw[D1] ^ cw[D3]};
    pe  = ^cw;
    fix = cw;
    // Syndrome names the 1-based position of a single flipped bit.
    if (syn != 3'd0 && pe) fix[syn - 3'd1] = ~cw[syn - 3'd1];
    // pe alone covers both a data/check-bit hit and a hit on the overall parity bit.
    sgl_err = pe;
    dbl_err = (syn != 3'd0) && !pe;
    nib     = {fix[D0], fix[D1], fix[D2], fix[D3]};
  end

endmodule

// File: rtl/hamming_rx_deframer.sv
// Serial SECDED deframer: two codewords per byte (high nibble first), single-entry
// valid/ready output register and saturating corrected/uncorrectable counters.
module hamming_rx_deframer
  import hamming_rx_deframer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_bit,
  input  logic             rx_bit_valid,
  input  logic             rx_sof,
  output logic [7:0]       out_data,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  localparam logic [2:0] LAST_BIT = 3'(CW_BITS - 1);

  state_e              state_q, state_d;
  logic [CW_BITS-1:0]  sh_q, sh_d, cw;
  logic [2:0]          cnt_q, cnt_d;
  logic [NIB_BITS-1:0] hi_nib_q, hi_nib_d, dec_nib;
  logic                hi_bad_q, hi_bad_d;
  logic                dec_sgl, dec_dbl, cw_done, byte_done;
  logic [7:0]          data_q, data_d;
  logic                err_q, err_d, vld_q, vld_d, ovf_q, ovf_d;
  logic [CNT_W-1:0]    corr_q, corr_d, uncorr_q, uncorr_d;

  // Codeword as it will look once the current bit lands; feeds the shared decoder.
  always_comb begin
    cw        = sh_q;
    cw[cnt_q] = rx_bit;
  end

  hamming_secded_dec u_dec (
    .cw      (cw),
    .nib     (dec_nib),
    .sgl_err (dec_sgl),
    .dbl_err (dec_dbl)
  );

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    hi_nib_d  = hi_nib_q;
    hi_bad_d  = hi_bad_q;
    cw_done   = 1'b0;
    byte_done = 1'b0;
    if (rx_bit_valid) begin
      if (rx_sof) begin
        sh_d    = '0;
        sh_d[0] = rx_bit;
        cnt_d   = 3'd1;
        state_d = HI;
      end else begin
        case (state_q)
          HI, LO: begin
            sh_d  = cw;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == LAST_BIT) begin
              cw_done = 1'b1;
              sh_d    = '0;
              cnt_d   = 3'd0;
              if (state_q == HI) begin
                hi_nib_d = dec_nib;
                hi_bad_d = dec_dbl;
                state_d  = LO;
              end else begin
                byte_done = 1'b1;
                state_d   = IDLE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    data_d   = data_q;
    err_d    = err_q;
    vld_d    = vld_q;
    ovf_d    = ovf_q;
    corr_d   = corr_q;
    uncorr_d = uncorr_q;
    if (vld_q && out_ready) vld_d = 1'b0;
    if (byte_done) begin
      if (vld_q && !out_ready) begin
        ovf_d = 1'b1;
      end else begin
        data_d = {hi_nib_q, dec_nib};
        err_d  = hi_bad_q | dec_dbl;
        vld_d  = 1'b1;
      end
    end
    if (cw_done && dec_sgl && corr_q != '1)   corr_d   = corr_q + 1'b1;
    if (cw_done && dec_dbl && uncorr_q != '1) uncorr_d = uncorr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      cnt_q    <= '0;
      hi_nib_q <= '0;
      hi_bad_q <= 1'b0;
      data_q   <= '0;
      err_q    <= 1'b0;
      vld_q    <= 1'b0;
      ovf_q    <= 1'b0;
      corr_q   <= '0;
      uncorr_q <= '0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      hi_nib_q <= hi_nib_d;
      hi_bad_q <= hi_bad_d;
      data_q   <= data_d;
      err_q    <= err_d;
      vld_q    <= vld_d;
      ovf_q    <= ovf_d;
      corr_q   <= corr_d;
      uncorr_q <= uncorr_d;
    end
  end

  assign out_data   = data_q;
  assign out_err    = err_q;
  assign out_valid  = vld_q;
  assign overflow   = ovf_q;
  assign corr_cnt   = corr_q;
  assign uncorr_cnt = uncorr_q;

endmodule

// File: doc/hamming_rx_deframer.md
Name: hamming_rx_deframer

Overview:
- Receive-side counterpart to the SECDED Hamming(7,4)+overall-parity encoder path.
- Accepts a serial channel bitstream and deserializes two 8-bit codewords per byte: the high nibble first, then the low nibble.
- SECDED-decodes each codeword, reassembles the byte and presents it on a valid/ready output.
- Keeps saturating counters of corrected and uncorrectable codewords for link-quality reporting.

Parameters:
- CNT_W, 16, width of the corrected/uncorrectable error counters (saturating).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- rx_bit  in  1  serial channel bit.
- rx_bit_valid  in  1  rx_bit is sampled this cycle when high.
- rx_sof  in  1  qualified by rx_bit_valid; marks rx_bit as the first bit of a byte frame.
- out_data  out  8  decoded byte, {hi_nibble, lo_nibble}.
- out_err  out  1  at least one nibble of out_data was uncorrectable.
- out_valid  out  1  out_data/out_err valid.
- out_ready  in  1  consumer accepts the byte when out_valid && out_ready.
- overflow  out  1  sticky; a completed byte was dropped because the output register was full.
- corr_cnt  out  CNT_W  codewords with a single error that was corrected.
- uncorr_cnt  out  CNT_W  codewords with a double error that was detected.

Behaviour:
- Reset (rst_n low at a clock edge):
  - State goes to IDLE and the shift register and bit counter clear.
  - out_data=0, out_err=0, out_valid=0, overflow=0, corr_cnt=0, uncorr_cnt=0.
  - Reset mid-frame discards the partial frame.
- Codeword layout, index 0 transmitted first: c[0:6] = p1,p2,d0,p4,d1,d2,d3, then c[7] = overall even parity of c[0:6].
  - Nibble d[0:3] has d0 as the MSB.
  - p1 = d0^d1^d3, p2 = d0^d2^d3, p4 = d1^d2^d3.
- Decode:
  - Syndrome s = {c[3]^d1^d2^d3, c[1]^d0^d2^d3, c[0]^d0^d1^d3}, interpreted as {s4,s2,s1}.
  - Overall check pe = XOR of c[0:7].
  - s=0, pe=0: clean.
  - s≠0, pe=1: single error; flip c[s-1] and increment corr_cnt.
  - s=0, pe=1: parity bit error; data is good; increment corr_cnt.
  - s≠0, pe=0: double error; pass data uncorrected, mark the nibble bad, increment uncorr_cnt.
  - Counters saturate at all-ones.
- FSM:
  - IDLE: wait for rx_bit_valid && rx_sof. That bit is stored as bit 0 and the FSM moves to HI.
  - HI: collect bits 1..7. The 8th bit completes the codeword: decode it, latch the nibble and its bad flag, then go to LO.
  - LO: collect 8 bits. When the 8th bit is accepted, decode, then load the output register and go to IDLE.
  - A new frame may begin on the cycle right after the last LO bit.
  - rx_sof asserted while in HI/LO: abort the partial frame and restart at HI with this bit as bit 0. No counter changes for the aborted frame.
  - rx_bit_valid low: hold state, no change.
  - rx_sof asserted without rx_bit_valid is ignored.
- Output register (single entry):
  - out_valid rises on the clock edge that accepts the last LO bit, so it is visible the cycle after that bit.
  - out_err = hi_bad | lo_bad.
  - out_data and out_err stay stable while out_valid && !out_ready.
  - out_valid clears on the accepting cycle unless a new byte completes in that same cycle. In that case the new byte loads and out_valid stays high.
  - A byte completing while out_valid && !out_ready is dropped: overflow is set (sticky until reset) and the held byte is kept.
  - Counters still update for a dropped byte.
- Throughput: 16 rx_bit_valid cycles per byte; no internal stalls.

Decomposition:
- Shared package holds:
  - codeword bit-index constants (P1,P2,D0,P4,D1,D2,D3,PALL);
  - the FSM state enum {IDLE,HI,LO};
  - the constants CW_BITS=8 and NIB_BITS=4.
- One sub-module is natural: hamming_secded_dec. It is purely combinational: c[0:7] -> d[0:3], single, double. It is instantiated once and shared between the HI and LO phases.

Test Plan:
- Clean byte: send 0xB44B MSB-first (the 0xA and 0x5 codewords) with rx_sof on the first bit, out_ready=1 -> out_data=0xA5, out_err=0, out_valid for 1 cycle, counters 0.
- Single error: send 0xBC4B (c[4] of the high codeword flipped) -> out_data=0xA5, out_err=0, corr_cnt=1, uncorr_cnt=0.
- Parity-bit-only error and double error:
  - First send 0xB54B (high c[7] flipped) -> out_data=0xA5, corr_cnt=1.
  - Then send 0x744B (high c[0],c[1] flipped) -> out_err=1, uncorr_cnt=1, out_data high nibble as received.
- Backpressure and overflow: hold out_ready=0 and send two clean frames (0xA5 then 0x00, stream 0x0000) -> out_data stays 0xA5, overflow=1. Then raise out_ready -> 0xA5 is accepted and out_valid drops.
- Resync and gaps:
  - Send 5 bits, then assert rx_sof and send the full 0xB44B with rx_bit_valid gaps inserted -> a single byte 0xA5, no counter change.
  - Assert rst_n=0 mid-frame -> all outputs 0, state IDLE.
